// File: rtl/kvaz_sdram_port_if.sv
// CPU-side and SDRAM-side signal bundle for kvaz_sdram_port.
// slave: the port sequencer; master: the CPU/mapper/controller environment.
interface kvaz_sdram_port_if #(
   parameter int PAGE_BITS = 3
);
   logic                    clke;
   logic [15:0]             address;
   logic [7:0]              data_in;
   logic                    memrd;
   logic                    memwr;
   logic [PAGE_BITS-1:0]    bigram_addr;
   logic                    ram_req;
   logic                    ram_we;
   logic [PAGE_BITS+15:0]   ram_addr;
   logic [7:0]              ram_wdata;
   logic                    ram_ack;
   logic [7:0]              ram_rdata;
   logic                    cpu_ready;
   logic [7:0]              cpu_rdata;
   logic                    timeout_err;

   modport slave (
      input  clke, address, data_in, memrd, memwr, bigram_addr,
      input  ram_ack, ram_rdata,
      output ram_req, ram_we, ram_addr, ram_wdata,
      output cpu_ready, cpu_rdata, timeout_err
   );

   modport master (
      output clke, address, data_in, memrd, memwr, bigram_addr,
      output ram_ack, ram_rdata,
      input  ram_req, ram_we, ram_addr, ram_wdata,
      input  cpu_ready, cpu_rdata, timeout_err
   );
endinterface

// File: rtl/kvaz_sdram_port.sv
// CPU-side SDRAM request sequencer: one req/ack per CPU memory cycle,
// CPU stall via cpu_ready, read return, sticky watchdog on a hung controller.
// Ports: clk, reset (sync, active-high), bus (kvaz_sdram_port_if.slave).
module kvaz_sdram_port #(
   parameter int PAGE_BITS   = 3,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   kvaz_sdram_port_if.slave      bus
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [7:0] TO_CNT = 8'(TIMEOUT_CYC);

   logic [1:0]            r_state;
   logic [7:0]            r_cnt;
   logic                  r_req;
   logic                  r_we;
   logic [PAGE_BITS+15:0] r_addr;
   logic [7:0]            r_wdata;
   logic                  r_ready;
   logic [7:0]            r_rdata;
   logic                  r_terr;

   logic                  w_strobe;
   logic [7:0]            w_cnt_nxt;

   assign w_strobe  = bus.memrd | bus.memwr;
   assign w_cnt_nxt = r_cnt + 8'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_req   <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_ready <= 1'b1;
         r_rdata <= 8'hFF;
         r_terr  <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (bus.clke && w_strobe) begin
                  r_addr  <= {bus.bigram_addr, bus.address};
                  r_wdata <= bus.data_in;
                  // a simultaneous read+write strobe is served as a write
                  r_we    <= bus.memwr;
                  r_req   <= 1'b1;
                  r_ready <= 1'b0;
                  r_cnt   <= '0;
                  r_state <= S_BUSY;
               end
            end
            S_BUSY: begin
               // stays at TO_CNT after an abort until DONE exits
               r_cnt <= w_cnt_nxt;
               if (bus.ram_ack) begin
                  r_req   <= 1'b0;
                  r_ready <= 1'b1;
                  if (!r_we)
                     r_rdata <= bus.ram_rdata;
                  r_state <= S_DONE;
               end else if (w_cnt_nxt == TO_CNT) begin
                  r_req   <= 1'b0;
                  r_ready <= 1'b1;
                  r_terr  <= 1'b1;
                  if (!r_we)
                     r_rdata <= 8'hFF;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               // a strobe still held from the finished cycle must not re-issue
               if (bus.clke && !w_strobe) begin
                  r_cnt   <= '0;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.ram_req     = r_req;
   assign bus.ram_we      = r_we;
   assign bus.ram_addr    = r_addr;
   assign bus.ram_wdata   = r_wdata;
   assign bus.cpu_ready   = r_ready;
   assign bus.cpu_rdata   = r_rdata;
   assign bus.timeout_err = r_terr;
endmodule

// File: tb/tb_kvaz_sdram_port.sv
// Self-checking bench for kvaz_sdram_port: directed cases plus random
// transactions scored against a transaction-level model.
module tb_kvaz_sdram_port;
   logic clk;
   logic reset;

   kvaz_sdram_port_if #(.PAGE_BITS(3)) bus ();

   kvaz_sdram_port #(
      .PAGE_BITS   (3),
      .TIMEOUT_CYC (255)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // transaction-level model state
   logic [7:0] m_rdata;
   logic       m_terr;

   // ram_req rising-edge counter
   int   req_pulses = 0;
   logic req_prev   = 1'b0;
   always @(posedge clk) begin
      if (bus.ram_req && !req_prev)
         req_pulses++;
      req_prev = bus.ram_req;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic run_txn(input logic [2:0] pg, input logic [15:0] a,
                          input logic [7:0] d, input bit rd, input bit wr,
                          input int dly, input logic [7:0] rdat,
                          input int pre_idle, input int hold,
                          input bit hold_rand);
      logic [18:0] ea;
      logic        ewe;
      ea  = {pg, a};
      ewe = wr;
      bus.bigram_addr = pg;
      bus.address     = a;
      bus.data_in     = d;
      bus.memrd       = rd;
      bus.memwr       = wr;
      repeat (pre_idle) begin
         bus.clke = 1'b0;
         @(negedge clk);
         chk("noaccept", bus.ram_req, 0);
      end
      bus.clke = 1'b1;
      @(negedge clk);
      chk("req_hi", bus.ram_req, 1);
      chk("rdy_lo", bus.cpu_ready, 0);
      chk("addr", bus.ram_addr, ea);
      chk("we", bus.ram_we, ewe);
      if (wr)
         chk("wdata", bus.ram_wdata, d);
      // disturb the CPU side; request fields must stay frozen
      bus.clke        = 1'($urandom);
      bus.address     = 16'($urandom);
      bus.data_in     = 8'($urandom);
      bus.bigram_addr = 3'($urandom);
      repeat (dly) begin
         @(negedge clk);
         chk("hold", {bus.ram_req, bus.cpu_ready, bus.ram_we, bus.ram_addr},
             {1'b1, 1'b0, ewe, ea});
      end
      bus.ram_ack   = 1'b1;
      bus.ram_rdata = rdat;
      @(negedge clk);
      bus.ram_ack   = 1'b0;
      bus.ram_rdata = 8'($urandom);
      if (!wr)
         m_rdata = rdat;
      chk("req_lo", bus.ram_req, 0);
      chk("rdy_hi", bus.cpu_ready, 1);
      chk("rdata", bus.cpu_rdata, m_rdata);
      chk("terr", bus.timeout_err, m_terr);
      repeat (hold) begin
         bus.clke = hold_rand ? 1'($urandom) : 1'b1;
         @(negedge clk);
         chk("no_reissue", bus.ram_req, 0);
      end
      bus.memrd = 1'b0;
      bus.memwr = 1'b0;
      bus.clke  = 1'b1;
      @(negedge clk);
      bus.clke  = 1'b0;
      chk("idle_rdy", bus.cpu_ready, 1);
   endtask

   initial begin
      int cnt;
      int p0;
      logic [2:0] pg;
      int kind;

      m_rdata         = 8'hFF;
      m_terr          = 1'b0;
      bus.clke        = 1'b0;
      bus.address     = '0;
      bus.data_in     = '0;
      bus.memrd       = 1'b0;
      bus.memwr       = 1'b0;
      bus.bigram_addr = '0;
      bus.ram_ack     = 1'b0;
      bus.ram_rdata   = '0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk("rst_req", bus.ram_req, 0);
      chk("rst_we", bus.ram_we, 0);
      chk("rst_addr", bus.ram_addr, 0);
      chk("rst_wdata", bus.ram_wdata, 0);
      chk("rst_rdy", bus.cpu_ready, 1);
      chk("rst_rdata", bus.cpu_rdata, 8'hFF);
      chk("rst_terr", bus.timeout_err, 0);

      // read page 0, ack 3 clk after req
      run_txn(3'd0, 16'h1234, 8'h00, 1, 0, 3, 8'h5A, 1, 0, 0);
      chk("rd_5a", bus.cpu_rdata, 8'h5A);
      // write page 2, cpu_rdata keeps 5A
      run_txn(3'd2, 16'hA000, 8'hC3, 0, 1, 2, 8'h11, 0, 0, 0);
      chk("wr_keep", bus.cpu_rdata, 8'h5A);
      // immediate ack, then strobe held 10 clke cycles
      p0 = req_pulses;
      run_txn(3'd1, 16'h0042, 8'h00, 1, 0, 0, 8'h77, 0, 10, 0);
      chk("one_pulse", req_pulses - p0, 1);
      // read+write together
      run_txn(3'd4, 16'hBEEF, 8'h99, 1, 1, 1, 8'h22, 0, 1, 0);

      // random transactions
      for (int i = 0; i < 40; i++) begin
         pg   = 3'($urandom_range(0, 4));
         kind = $urandom_range(0, 2);
         p0   = req_pulses;
         run_txn(pg, 16'($urandom), 8'($urandom), kind != 1, kind != 0,
                 $urandom_range(0, 6), 8'($urandom),
                 $urandom_range(0, 2), $urandom_range(0, 3), 1);
         chk("rnd_pulse", req_pulses - p0, 1);
      end

      // watchdog: read never acked
      bus.bigram_addr = 3'd3;
      bus.address     = 16'h5555;
      bus.memrd       = 1'b1;
      bus.clke        = 1'b1;
      @(negedge clk);
      bus.clke = 1'b0;
      cnt = 0;
      while (bus.ram_req && cnt < 400) begin
         cnt++;
         @(negedge clk);
      end
      chk("tmo_len", cnt, 255);
      m_rdata = 8'hFF;
      m_terr  = 1'b1;
      chk("tmo_terr", bus.timeout_err, 1);
      chk("tmo_rdata", bus.cpu_rdata, 8'hFF);
      chk("tmo_rdy", bus.cpu_ready, 1);
      bus.memrd = 1'b0;
      bus.clke  = 1'b1;
      @(negedge clk);
      bus.clke = 1'b0;
      run_txn(3'd0, 16'h0100, 8'h00, 1, 0, 2, 8'h3C, 0, 0, 0);
      chk("post_tmo_terr", bus.timeout_err, 1);

      // reset mid-BUSY, late ack ignored
      bus.bigram_addr = 3'd1;
      bus.address     = 16'h7777;
      bus.memrd       = 1'b1;
      bus.clke        = 1'b1;
      @(negedge clk);
      bus.clke = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset     = 1'b0;
      bus.memrd = 1'b0;
      m_rdata   = 8'hFF;
      m_terr    = 1'b0;
      chk("mrst_req", bus.ram_req, 0);
      chk("mrst_rdy", bus.cpu_ready, 1);
      chk("mrst_addr", bus.ram_addr, 0);
      chk("mrst_terr", bus.timeout_err, m_terr);
      p0 = req_pulses;
      @(negedge clk);
      bus.ram_ack   = 1'b1;
      bus.ram_rdata = 8'h55;
      @(negedge clk);
      bus.ram_ack = 1'b0;
      @(negedge clk);
      chk("late_req", bus.ram_req, 0);
      chk("late_rdy", bus.cpu_ready, 1);
      chk("late_rdata", bus.cpu_rdata, m_rdata);
      chk("late_pulse", req_pulses - p0, 0);
      // port still usable
      run_txn(3'd2, 16'h0F0F, 8'h00, 1, 0, 1, 8'hA5, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
